// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
//   Groups the write-back request, flow-control and register-file write
//   signals that run between the pipelines and the write-back arbiter.
//   master : the side that raises requests and observes the write port
//   slave  : the arbiter
//   Signals:
//     alu_valid/alu_rd/alu_data : ALU/MEM pipe write request (no back-pressure)
//     ld_valid/ld_rd/ld_data    : long-latency write request
//     ld_ready                  : long-latency request accepted this cycle
//     alu_stall                 : ALU pipe must not issue this cycle
//     RegWrite/rc/dc            : registered register-file write port
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        alu_stall;
    logic        RegWrite;
    logic [4:0]  rc;
    logic [31:0] dc;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  ld_ready, alu_stall, RegWrite, rc, dc
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output ld_ready, alu_stall, RegWrite, rc, dc
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Shares a single register-file write port between the ALU/MEM pipe and
//   the long-latency (load/mul/div) unit. ALU writes always win; a colliding
//   long-latency write is parked in a one-entry buffer and drained when the
//   port is free, or forced out by stalling the ALU pipe after it has lost
//   STALL_LIMIT cycles in a row.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : wb_arbiter_if.slave (requests, ld_ready, alu_stall, write port)
module wb_arbiter #(
    parameter int unsigned STALL_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [4:0]        buf_rd_q, buf_rd_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              we_q, we_d;
    logic [4:0]        rc_q, rc_d;
    logic [31:0]       dc_q, dc_d;

    logic              alu_req;
    logic              ld_req;

    // rd=0 targets the hardwired zero register, so it never produces a write.
    assign alu_req = bus.alu_valid && (bus.alu_rd != '0);
    // Only sampled in IDLE, where ld_ready is high; rd=0 is accepted and dropped.
    assign ld_req  = bus.ld_valid && (bus.ld_rd != '0);

    // Saturating so the counter can never wrap.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        we_d       = 1'b0;
        rc_d       = rc_q;
        dc_d       = dc_q;

        unique case (state_q)
            IDLE: begin
                if (alu_req) begin
                    we_d = 1'b1;
                    rc_d = bus.alu_rd;
                    dc_d = bus.alu_data;
                    // Same rd: the ALU result is younger, so the load is dead.
                    if (ld_req && (bus.ld_rd != bus.alu_rd)) begin
                        buf_rd_d   = bus.ld_rd;
                        buf_data_d = bus.ld_data;
                        cnt_d      = '0;
                        state_d    = HELD;
                    end
                end else if (ld_req) begin
                    we_d = 1'b1;
                    rc_d = bus.ld_rd;
                    dc_d = bus.ld_data;
                end
            end
            HELD: begin
                if (alu_req) begin
                    we_d = 1'b1;
                    rc_d = bus.alu_rd;
                    dc_d = bus.alu_data;
                    if (bus.alu_rd == buf_rd_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LIMIT) begin
                            state_d = FORCE;
                        end
                    end
                end else begin
                    we_d    = 1'b1;
                    rc_d    = buf_rd_q;
                    dc_d    = buf_data_q;
                    state_d = IDLE;
                end
            end
            FORCE: begin
                // Any alu_valid here violates the stall and is ignored.
                we_d    = 1'b1;
                rc_d    = buf_rd_q;
                dc_d    = buf_data_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            we_q       <= 1'b0;
            rc_q       <= '0;
            dc_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            we_q       <= we_d;
            rc_q       <= rc_d;
            dc_q       <= dc_d;
        end
    end

    assign bus.ld_ready  = (state_q == IDLE);
    assign bus.alu_stall = (state_q == FORCE);
    assign bus.RegWrite  = we_q;
    assign bus.rc        = rc_q;
    assign bus.dc        = dc_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//   Directed stimulus for wb_arbiter with a transaction-level reference model
//   (a pending-write queue plus a lost-cycle count) checked every cycle, and
//   literal expectations for the documented scenarios.
module tb_wb_arbiter;

    localparam int unsigned LIM = 3;

    logic clk;
    logic rst_n;

    wb_arbiter_if bus ();

    wb_arbiter #(.STALL_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total;
    int unsigned bad;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         pend[$];
    int unsigned losses;
    logic        exp_we;
    logic [4:0]  exp_rc;
    logic [31:0] exp_dc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_stall();
        return (pend.size() != 0) && (losses == LIM);
    endfunction

    task automatic model_reset();
        pend.delete();
        losses = 0;
        exp_we = 1'b0;
        exp_rc = '0;
        exp_dc = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] data);
        exp_we = 1'b1;
        exp_rc = rd;
        exp_dc = data;
    endtask

    // Apply one cycle of requests and advance the model to what the write port
    // must show after the next rising edge.
    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        logic alu;
        logic ld_acc;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ldat;

        alu    = av && (ard != 0) && !model_stall();
        ld_acc = lv && (pend.size() == 0) && (lrd != 0);
        exp_we = 1'b0;
        if (pend.size() == 0) begin
            if (alu) begin
                issue(ard, ad);
                if (ld_acc && (lrd != ard)) begin
                    pend.push_back('{rd: lrd, data: ldat});
                    losses = 0;
                end
            end else if (ld_acc) begin
                issue(lrd, ldat);
            end
        end else if (model_stall() || !alu) begin
            issue(pend[0].rd, pend[0].data);
            void'(pend.pop_front());
        end else begin
            issue(ard, ad);
            if (ard == pend[0].rd) void'(pend.pop_front());
            else losses++;
        end
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Wait for the sampling edge and compare every output against the model.
    task automatic cyc();
        @(negedge clk);
        chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, exp_we});
        chk("rc", {27'd0, bus.rc}, {27'd0, exp_rc});
        chk("dc", bus.dc, exp_dc);
        chk("ld_ready", {31'd0, bus.ld_ready}, {31'd0, pend.size() == 0});
        chk("alu_stall", {31'd0, bus.alu_stall}, {31'd0, model_stall()});
        if (bus.RegWrite === 1'b1 && bus.rc === 5'd0) chk("rc_zero_write", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
    } vec_t;

    vec_t mix[$];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        model_reset();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;

        #1;
        chk("rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("rst_rc", {27'd0, bus.rc}, 32'd0);
        chk("rst_dc", bus.dc, 32'd0);
        chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("rst_alu_stall", {31'd0, bus.alu_stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone ALU write.
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0); cyc();
        chk("r28_we", {31'd0, bus.RegWrite}, 32'd1);
        chk("r28_rc", {27'd0, bus.rc}, 32'd5);
        chk("r28_dc", bus.dc, 32'h11);
        idle(); cyc();
        chk("r28_we_off", {31'd0, bus.RegWrite}, 32'd0);

        // Collision with differing rd: ld buffered, drained next free cycle.
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB); cyc();
        chk("r29_rc1", {27'd0, bus.rc}, 32'd3);
        chk("r29_dc1", bus.dc, 32'hA);
        chk("r29_rdy1", {31'd0, bus.ld_ready}, 32'd0);
        idle(); cyc();
        chk("r29_rc2", {27'd0, bus.rc}, 32'd4);
        chk("r29_dc2", bus.dc, 32'hB);
        chk("r29_rdy2", {31'd0, bus.ld_ready}, 32'd1);

        // Starvation: three ALU wins then a forced slot.
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77); cyc();
        drive(1'b1, 5'd8, 32'h8, 1'b0, 5'd0, 32'd0); cyc();
        drive(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'd0); cyc();
        chk("r30_nostall", {31'd0, bus.alu_stall}, 32'd0);
        drive(1'b1, 5'd10, 32'h10, 1'b0, 5'd0, 32'd0); cyc();
        chk("r30_stall", {31'd0, bus.alu_stall}, 32'd1);
        chk("r30_rc10", {27'd0, bus.rc}, 32'd10);
        idle(); cyc();
        chk("r30_rc7", {27'd0, bus.rc}, 32'd7);
        chk("r30_dc7", bus.dc, 32'h77);
        chk("r30_stall_off", {31'd0, bus.alu_stall}, 32'd0);
        chk("r30_rdy", {31'd0, bus.ld_ready}, 32'd1);

        // Buffered entry overwritten by a younger ALU write to the same rd.
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66); cyc();
        drive(1'b1, 5'd6, 32'h55, 1'b0, 5'd0, 32'd0); cyc();
        chk("r31_rc", {27'd0, bus.rc}, 32'd6);
        chk("r31_dc", bus.dc, 32'h55);
        chk("r31_rdy", {31'd0, bus.ld_ready}, 32'd1);
        idle(); cyc();
        chk("r31_we_off", {31'd0, bus.RegWrite}, 32'd0);
        chk("r31_dc_hold", bus.dc, 32'h55);

        // rd=0 requests never write.
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF); cyc();
        chk("r32_we0", {31'd0, bus.RegWrite}, 32'd0);

        // Mixed directed sequence checked by the model only.
        mix = '{
            '{1'b1, 5'd0,  32'hF0, 1'b1, 5'd9,  32'h99},
            '{1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC1},
            '{1'b1, 5'd13, 32'hD3, 1'b0, 5'd0,  32'h0},
            '{1'b1, 5'd12, 32'hEE, 1'b0, 5'd0,  32'h0},
            '{1'b0, 5'd0,  32'h0,  1'b1, 5'd14, 32'hD1},
            '{1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 32'h16},
            '{1'b1, 5'd17, 32'h17, 1'b1, 5'd18, 32'h18},
            '{1'b1, 5'd19, 32'h19, 1'b0, 5'd0,  32'h0},
            '{1'b1, 5'd20, 32'h20, 1'b0, 5'd0,  32'h0},
            '{1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22},
            '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0}
        };
        foreach (mix[i]) begin
            drive(mix[i].av, mix[i].ard, mix[i].ad, mix[i].lv, mix[i].lrd, mix[i].ldat);
            cyc();
        end
        chk("mix_last_rc", {27'd0, bus.rc}, 32'd16);

        // Reset while an entry is buffered: it must be lost.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44); cyc();
        chk("r32_held", {31'd0, bus.ld_ready}, 32'd0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("r32_rst_we", {31'd0, bus.RegWrite}, 32'd0);
        chk("r32_rst_rdy", {31'd0, bus.ld_ready}, 32'd1);
        chk("r32_rst_rc", {27'd0, bus.rc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); cyc();
        idle(); cyc();
        chk("r32_no_drain", {31'd0, bus.RegWrite}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 3: number of HELD cycles the buffered long-latency write may lose to ALU writes before a forced slot.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port alu_valid, input, 1 bit: ALU/MEM pipe write request, no back-pressure.
REQ-005 SHALL have port alu_rd, input, 5 bits: destination register of the ALU write.
REQ-006 SHALL have port alu_data, input, 32 bits: ALU write data.
REQ-007 SHALL have port ld_valid, input, 1 bit: long-latency (load/mul/div) write request.
REQ-008 SHALL have port ld_rd, input, 5 bits, and port ld_data, input, 32 bits: long-latency destination and data.
REQ-009 SHALL have port ld_ready, output, 1 bit: long-latency request accepted when ld_valid && ld_ready.
REQ-010 SHALL have port alu_stall, output, 1 bit: upstream SHALL hold alu_valid=0 in any cycle alu_stall=1.
REQ-011 SHALL have ports RegWrite, output, 1 bit; rc, output, 5 bits; dc, output, 32 bits: registered write port driving the register file.

Function
REQ-012 SHALL drive RegWrite/rc/dc from flops; a selected write appears on them one cycle after its request cycle.
REQ-013 SHALL treat alu_valid with alu_rd=0 as no request; SHALL accept ld requests with ld_rd=0 and drop them; RegWrite SHALL never be 1 with rc=0.
REQ-014 SHALL implement states IDLE (buffer empty), HELD (one buffered ld entry), FORCE (draining buffer under stall).
REQ-015 SHALL drive ld_ready=1 only in IDLE and alu_stall=1 only in FORCE, both decoded from registered state.
REQ-016 IDLE, ALU only: SHALL issue the ALU write; stay IDLE.
REQ-017 IDLE, ld only: SHALL issue the ld write directly; stay IDLE.
REQ-018 IDLE, both, rd differ: SHALL issue ALU write, capture ld into buffer, clear wait counter, go HELD.
REQ-019 IDLE, both, same rd: SHALL issue ALU write, discard ld (ALU is younger in program order), stay IDLE.
REQ-020 HELD, no ALU: SHALL issue buffered write, go IDLE.
REQ-021 HELD, ALU with rd equal to buffered rd: SHALL issue ALU write, discard buffer, go IDLE.
REQ-022 HELD, ALU with different rd: SHALL issue ALU write, increment wait counter; when incremented value equals STALL_LIMIT go FORCE, else stay HELD.
REQ-023 FORCE: SHALL issue buffered write, go IDLE; alu_valid in FORCE is a protocol violation, SHALL be ignored.
REQ-024 SHALL issue at most one write per cycle; when nothing is issued RegWrite=0, rc and dc hold previous values.
REQ-025 Wait counter SHALL be ceil(log2(STALL_LIMIT+1)) bits and SHALL never wrap.

Reset
REQ-026 On rst_n=0 SHALL immediately force IDLE, RegWrite=0, rc=0, dc=0, ld_ready=1, alu_stall=0, wait counter=0; any buffered entry is lost.
REQ-027 SHALL resume normal operation at the first rising clk edge after rst_n deasserts.

Verification
REQ-028 ALU rd=5 data=0x11 alone -> next cycle RegWrite=1, rc=5, dc=0x11; following cycle RegWrite=0.
REQ-029 Same cycle ALU rd=3 data=0xA and ld rd=4 data=0xB, then idle -> cycle+1 rc=3 dc=0xA, ld_ready=0; cycle+2 rc=4 dc=0xB; ld_ready=1 again after.
REQ-030 ld rd=7 buffered, ALU writes rd=8,9,10 on three consecutive cycles -> alu_stall=1 the following cycle, rc=7 written that cycle, then alu_stall=0, ld_ready=1.
REQ-031 ld rd=6 buffered, next ALU rd=6 data=0x55 -> rc=6 dc=0x55 written once, buffered value never written, state IDLE.
REQ-032 ALU rd=0 and ld rd=0 -> RegWrite stays 0; rst_n pulsed low while HELD -> RegWrite=0, ld_ready=1 immediately, buffered write never issued.
